inbox_fifo: RTL

//   Input-queue (INBOX) buffer feeding the CPU control unit and datapath.
//   An external producer (UART/loader/testbench) pushes words; the CPU pops one word per INBOX

---
 rtl/inbox_fifo.sv | 128 ++++++++++++
 1 files changed

// File: rtl/inbox_fifo.sv
// Show-ahead input queue feeding the CPU: the head word is always presented on o_data,
// and the occupancy flags come from registers so they never ripple from the inputs.
module inbox_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_wr,
  output logic             o_full,
  input  logic             rIn,
  output logic [WIDTH-1:0] o_data,
  output logic             inEmpty,
  output logic [AW:0]      o_count,
  output logic             o_ovf,
  output logic             o_udf
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_ovf;
  logic             r_udf;
  logic [WIDTH-1:0] r_data;

  logic             w_do_wr;
  logic             w_do_rd;
  logic [AW-1:0]    w_wr_ptr_nxt;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [AW:0]      w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  // Effective operations and the post-edge pointers, count and head word.
  always_comb begin
    w_do_rd = rIn & ~r_empty;
    w_do_wr = i_wr & (~r_full | w_do_rd);

    if (w_do_wr) begin
      w_wr_ptr_nxt = r_wr_ptr + AW'(1);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end

    if (w_do_rd) begin
      w_rd_ptr_nxt = r_rd_ptr + AW'(1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end

    case ({w_do_wr, w_do_rd})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase

    // The word being written this cycle becomes the head when it lands on the next read slot.
    if (w_count_nxt == (AW+1)'(0)) begin
      w_head_nxt = {WIDTH{1'b0}};
    end else if (w_do_wr && (w_rd_ptr_nxt == r_wr_ptr)) begin
      w_head_nxt = i_data;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (!i_clr && w_do_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, count, registered flags and registered head word.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_data   <= {WIDTH{1'b0}};
    end else if (i_clr) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_data   <= {WIDTH{1'b0}};
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == FULL_CNT);
      r_empty  <= (w_count_nxt == (AW+1)'(0));
      r_data   <= w_head_nxt;
      if (i_wr && r_full && !w_do_rd) begin
        r_ovf <= 1'b1;
      end else begin
        r_ovf <= r_ovf;
      end
      if (rIn && r_empty) begin
        r_udf <= 1'b1;
      end else begin
        r_udf <= r_udf;
      end
    end
  end

  assign o_full  = r_full;
  assign inEmpty = r_empty;
  assign o_count = r_count;
  assign o_ovf   = r_ovf;
  assign o_udf   = r_udf;
  assign o_data  = r_data;

endmodule
